// File: rtl/io_port_responder.sv
// CPU I/O port responder: 4-deep RX byte FIFO, status/control ports, LED register.
// Optional feature macro IO_RESPONDER_IRQ_EN enables the interrupt-enable bit and irq output.
module io_port_responder (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] port_id,
   input  logic [7:0] out_port,
   input  logic       io_strb,
   output logic [7:0] in_port,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] led,
   output logic       irq
);

   localparam logic [7:0] PORT_RX_DATA = 8'h30;
   localparam logic [7:0] PORT_STATUS  = 8'h31;
   localparam logic [7:0] PORT_POP     = 8'h32;
   localparam logic [7:0] PORT_CTRL    = 8'h33;
   localparam logic [7:0] PORT_LED     = 8'h40;

   logic [7:0] r_mem [0:3];
   logic [1:0] r_rd_ptr;
   logic [1:0] r_wr_ptr;
   logic [2:0] r_count;
   logic       r_ovf;
   logic       r_ie;
   logic [7:0] r_led;
   logic       r_irq;

   logic       w_pop_req;
   logic       w_ctrl_wr;
   logic       w_led_wr;
   logic       w_pop;
   logic       w_push;
   logic       w_full;
   logic       w_ovf_set;
   logic       w_ie_next;
   logic [2:0] w_count_next;

   assign w_pop_req = io_strb && (port_id == PORT_POP);
   assign w_ctrl_wr = io_strb && (port_id == PORT_CTRL);
   assign w_led_wr  = io_strb && (port_id == PORT_LED);
   assign w_full    = (r_count == 3'd4);
   assign w_pop     = w_pop_req && (r_count != 3'd0);
   // A full FIFO still accepts a byte when the head leaves in the same cycle
   assign w_push    = rx_valid && (!w_full || w_pop);
   assign w_ovf_set = rx_valid && w_full && !w_pop;

`ifdef IO_RESPONDER_IRQ_EN
   assign w_ie_next = w_ctrl_wr ? out_port[1] : r_ie;
`else
   assign w_ie_next = 1'b0;
`endif

   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + 3'd1;
         2'b01:   w_count_next = r_count - 3'd1;
         default: w_count_next = r_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_ptr <= 2'd0;
         r_wr_ptr <= 2'd0;
         r_count  <= 3'd0;
         r_ovf    <= 1'b0;
         r_ie     <= 1'b0;
         r_led    <= 8'h00;
         r_irq    <= 1'b0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 2'd1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 2'd1;
         r_count <= w_count_next;
         // A fresh overflow wins over a simultaneous clear
         if (w_ovf_set)
            r_ovf <= 1'b1;
         else if (w_ctrl_wr && out_port[0])
            r_ovf <= 1'b0;
         r_ie <= w_ie_next;
         if (w_led_wr)
            r_led <= out_port;
         r_irq <= w_ie_next && (w_count_next != 3'd0);
      end
   end

   // Storage is not reset; count=0 masks stale contents on the read port
   always_ff @(posedge clk) begin
      if (w_push && !rst)
         r_mem[r_wr_ptr] <= rx_data;
   end

   always_comb begin
      in_port = 8'h00;
      case (port_id)
         PORT_RX_DATA: in_port = (r_count != 3'd0) ? r_mem[r_rd_ptr] : 8'h00;
         PORT_STATUS:  in_port = {3'b000, r_ie, r_ovf, r_count};
         PORT_LED:     in_port = r_led;
         default:      in_port = 8'h00;
      endcase
   end

   assign led = r_led;
   assign irq = r_irq;

endmodule

// File: tb/tb_io_port_responder.sv
// Directed self-checking bench for io_port_responder; expectations follow the
// IO_RESPONDER_IRQ_EN build setting.
module tb_io_port_responder;

`ifdef IO_RESPONDER_IRQ_EN
   localparam bit IE_EN = 1'b1;
`else
   localparam bit IE_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] port_id = 8'h00;
   logic [7:0] out_port = 8'h00;
   logic       io_strb = 1'b0;
   logic [7:0] in_port;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic [7:0] led;
   logic       irq;

   int n_cmp = 0;
   int n_err = 0;

   io_port_responder dut (
      .clk      (clk),
      .rst      (rst),
      .port_id  (port_id),
      .out_port (out_port),
      .io_strb  (io_strb),
      .in_port  (in_port),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .led      (led),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-14s observed=%h expected=%h", tag, obs, exp);
   endtask

   // One clock with the given strobes; inputs are released 1ns after the edge.
   task automatic cyc(input logic strb, input logic [7:0] pid, input logic [7:0] dat,
                      input logic rxv, input logic [7:0] rxd);
      io_strb  = strb;
      port_id  = pid;
      out_port = dat;
      rx_valid = rxv;
      rx_data  = rxd;
      @(posedge clk);
      #1;
      io_strb  = 1'b0;
      rx_valid = 1'b0;
   endtask

   task automatic push(input logic [7:0] b);
      cyc(1'b0, 8'h00, 8'h00, 1'b1, b);
   endtask

   task automatic pop();
      cyc(1'b1, 8'h32, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic outp(input logic [7:0] pid, input logic [7:0] dat);
      cyc(1'b1, pid, dat, 1'b0, 8'h00);
   endtask

   task automatic rd(input logic [7:0] pid, input string tag, input logic [7:0] exp);
      port_id = pid;
      #1;
      chk(tag, in_port, exp);
   endtask

   // Reset for one edge while also presenting a push and a LED write.
   task automatic do_reset();
      rst      = 1'b1;
      io_strb  = 1'b1;
      port_id  = 8'h40;
      out_port = 8'hA5;
      rx_valid = 1'b1;
      rx_data  = 8'h99;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      io_strb  = 1'b0;
      rx_valid = 1'b0;
   endtask

   initial begin
      // Scenario 1: power-up reset
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      rd(8'h30, "s1_rxdata", 8'h00);
      rd(8'h31, "s1_status", 8'h00);
      rd(8'h40, "s1_ledrd", 8'h00);
      chk("s1_led", led, 8'h00);
      chk("s1_irq", {7'b0, irq}, 8'h00);

      // Scenario 2: basic push/pop, non-destructive read, ignored write
      push(8'hA1);
      push(8'hB2);
      push(8'hC3);
      rd(8'h31, "s2_status3", 8'h03);
      rd(8'h30, "s2_head_a1", 8'hA1);
      rd(8'h30, "s2_head_again", 8'hA1);
      pop();
      rd(8'h30, "s2_head_b2", 8'hB2);
      rd(8'h31, "s2_status2", 8'h02);
      outp(8'h30, 8'hFF);
      rd(8'h31, "s2_ign_status", 8'h02);
      rd(8'h30, "s2_ign_head", 8'hB2);

      // Scenario 3: overflow, sticky ovf, clear, clear-vs-overflow race
      do_reset();
      rd(8'h31, "s3_rst_status", 8'h00);
      push(8'h01);
      push(8'h02);
      push(8'h03);
      push(8'h04);
      rd(8'h31, "s3_full", 8'h04);
      push(8'hEE);
      rd(8'h31, "s3_ovf", 8'h0C);
      rd(8'h30, "s3_pop1", 8'h01);
      pop();
      rd(8'h30, "s3_pop2", 8'h02);
      pop();
      rd(8'h30, "s3_pop3", 8'h03);
      pop();
      rd(8'h30, "s3_pop4", 8'h04);
      pop();
      rd(8'h31, "s3_empty_ovf", 8'h08);
      rd(8'h30, "s3_empty_rd", 8'h00);
      pop();
      rd(8'h31, "s3_pop_empty", 8'h08);
      outp(8'h33, 8'h01);
      rd(8'h31, "s3_clr", 8'h00);
      push(8'h10);
      push(8'h11);
      push(8'h12);
      push(8'h13);
      cyc(1'b1, 8'h33, 8'h01, 1'b1, 8'hEE);
      rd(8'h31, "s3_clr_race", 8'h0C);
      outp(8'h33, 8'h01);
      rd(8'h31, "s3_clr2", 8'h04);
      rd(8'h30, "s3_head10", 8'h10);

      // Scenario 4: simultaneous pop and push on a full FIFO
      do_reset();
      push(8'h11);
      push(8'h22);
      push(8'h33);
      push(8'h44);
      cyc(1'b1, 8'h32, 8'h00, 1'b1, 8'h55);
      rd(8'h31, "s4_status", 8'h04);
      rd(8'h30, "s4_pop22", 8'h22);
      pop();
      rd(8'h30, "s4_pop33", 8'h33);
      pop();
      rd(8'h30, "s4_pop44", 8'h44);
      pop();
      rd(8'h30, "s4_pop55", 8'h55);
      pop();
      rd(8'h31, "s4_empty", 8'h00);

      // Scenario 5: interrupt enable and irq latency
      outp(8'h33, 8'h02);
      chk("s5_irq_empty", {7'b0, irq}, 8'h00);
      rd(8'h31, "s5_status_ie", IE_EN ? 8'h10 : 8'h00);
      push(8'h7F);
      chk("s5_irq_push", {7'b0, irq}, IE_EN ? 8'h01 : 8'h00);
      rd(8'h31, "s5_status_1", IE_EN ? 8'h11 : 8'h01);
      pop();
      chk("s5_irq_pop", {7'b0, irq}, 8'h00);

      // Scenario 6: LED register, ignored port, reset mid-stream
      outp(8'h40, 8'h5A);
      chk("s6_led", led, 8'h5A);
      rd(8'h40, "s6_led_rd", 8'h5A);
      outp(8'h41, 8'hFF);
      chk("s6_led_keep", led, 8'h5A);
      rd(8'h41, "s6_rd_other", 8'h00);
      push(8'h3C);
      outp(8'h33, 8'h02);
      do_reset();
      chk("s6_rst_led", led, 8'h00);
      chk("s6_rst_irq", {7'b0, irq}, 8'h00);
      rd(8'h31, "s6_rst_status", 8'h00);
      rd(8'h30, "s6_rst_rxdata", 8'h00);
      push(8'h9C);
      rd(8'h30, "s6_after_rst", 8'h9C);
      rd(8'h31, "s6_after_stat", 8'h01);
      chk("s6_after_irq", {7'b0, irq}, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
